// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Decode-stage immediate generator with a 1-cycle registered output and a
//   2-entry (output + skid) buffer. This lets the consumer stall without
//   losing or duplicating immediates.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   instr      raw 32-bit instruction word
//   ImmSrc     format select: 0 I, 1 S, 2 B, 3 U, 4 J, 5 shamt, 6 zimm, 7 reserved
//   in_valid   instr/ImmSrc valid
//   in_ready   block can accept an input this cycle (registered, = !skid valid)
//   imm_ext    extended immediate, XLEN wide
//   imm_err    imm_ext came from the reserved format
//   out_valid  imm_ext/imm_err valid
//   out_ready  consumer accepts the output this cycle
module imm_extend_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic [2:0]      ImmSrc,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] imm_ext,
  output logic            imm_err,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef struct packed {
    logic            vld;
    logic            err;
    logic [XLEN-1:0] imm;
  } ent_t;

  ent_t or_q, or_d;
  ent_t sk_q, sk_d;
  ent_t new_ent;

  logic [31:0] raw;
  logic        sext;
  logic        acc;
  logic        unused_bits;

  // The opcode field never contributes to an immediate.
  assign unused_bits = ^instr[6:0];

  // Build a 32-bit immediate first. Sign-extending formats are then widened
  // from bit 31, so XLEN=64 needs no format-specific code.
  always_comb begin
    raw  = '0;
    sext = 1'b1;
    case (ImmSrc)
      3'b000: raw = {{20{instr[31]}}, instr[31:20]};
      3'b001: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010: raw = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011: raw = {instr[31:12], 12'h000};
      3'b100: raw = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      3'b101: begin
        sext = 1'b0;
        raw  = (XLEN == 32) ? {27'd0, instr[24:20]} : {26'd0, instr[25:20]};
      end
      3'b110: begin
        sext = 1'b0;
        raw  = {27'd0, instr[19:15]};
      end
      default: begin
        sext = 1'b0;
        raw  = '0;
      end
    endcase
  end

  always_comb begin
    new_ent     = '0;
    new_ent.vld = 1'b1;
    new_ent.err = (ImmSrc == 3'b111);
    new_ent.imm = sext ? XLEN'($signed(raw)) : XLEN'(raw);
  end

  assign acc = in_valid && in_ready;

  always_comb begin
    or_d = or_q;
    sk_d = sk_q;
    if (!or_q.vld || out_ready) begin
      // OR is free this edge: the skid entry is older, so it goes first.
      if (sk_q.vld) begin
        or_d = sk_q;
        sk_d = acc ? new_ent : '0;
      end else if (acc) begin
        or_d = new_ent;
      end else begin
        or_d = '0;
      end
    end else if (acc) begin
      sk_d = new_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      or_q <= '0;
      sk_q <= '0;
    end else begin
      or_q <= or_d;
      sk_q <= sk_d;
    end
  end

  assign in_ready  = !sk_q.vld;
  assign out_valid = or_q.vld;
  assign imm_ext   = or_q.imm;
  assign imm_err   = or_q.err;

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic [2:0]  ImmSrc = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;

  logic        ir32, ov32, er32;
  logic [31:0] im32;
  logic        ir64, ov64, er64;
  logic [63:0] im64;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .instr(instr), .ImmSrc(ImmSrc),
    .in_valid(in_valid), .in_ready(ir32), .imm_ext(im32), .imm_err(er32),
    .out_valid(ov32), .out_ready(out_ready)
  );

  imm_extend_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .instr(instr), .ImmSrc(ImmSrc),
    .in_valid(in_valid), .in_ready(ir64), .imm_ext(im64), .imm_err(er64),
    .out_valid(ov64), .out_ready(out_ready)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    instr    = v.instr;
    ImmSrc   = v.src;
    in_valid = 1'b1;
  endtask

  task automatic exp_chk(input string nm, input vec_t v);
    check({nm, " ov32"}, 64'(ov32), 64'd1);
    check({nm, " ov64"}, 64'(ov64), 64'd1);
    check({nm, " imm32"}, 64'(im32), 64'(v.e32));
    check({nm, " imm64"}, im64, v.e64);
    check({nm, " err32"}, 64'(er32), 64'(v.err));
    check({nm, " err64"}, 64'(er64), 64'(v.err));
  endtask

  task automatic idle_chk(input string nm);
    check({nm, " ov32"}, 64'(ov32), 64'd0);
    check({nm, " ov64"}, 64'(ov64), 64'd0);
  endtask

  function automatic exp_t model(input logic [31:0] w, input logic [2:0] src);
    exp_t r;
    logic s;
    logic [63:0] v;
    s = w[31];
    r.err = 1'b0;
    case (src)
      3'd0: v = {{52{s}}, w[31:20]};
      3'd1: v = {{52{s}}, w[31:25], w[11:7]};
      3'd2: v = {{52{s}}, w[7], w[30:25], w[11:8], 1'b0};
      3'd3: v = {{32{s}}, w[31:12], 12'h000};
      3'd4: v = {{44{s}}, w[19:12], w[20], w[30:21], 1'b0};
      3'd5: v = {58'd0, w[25:20]};
      3'd6: v = {59'd0, w[19:15]};
      default: begin v = '0; r.err = 1'b1; end
    endcase
    r.e64 = v;
    r.e32 = (src == 3'd5) ? {27'd0, w[24:20]} : v[31:0];
    return r;
  endfunction

  vec_t vt[14];
  exp_t q[$];

  initial begin
    vt[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vt[1]  = '{32'hFE112E23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vt[2]  = '{32'hFE000CE3, 3'd2, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0};
    vt[3]  = '{32'h0010006F, 3'd4, 32'h00000800, 64'h0000000000000800, 1'b0};
    vt[4]  = '{32'h123450B7, 3'd3, 32'h12345000, 64'h0000000012345000, 1'b0};
    vt[5]  = '{32'h03F09093, 3'd5, 32'h0000001F, 64'h000000000000003F, 1'b0};
    vt[6]  = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};
    vt[7]  = '{32'h800000B7, 3'd3, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vt[8]  = '{32'h3407D073, 3'd6, 32'h0000000F, 64'h000000000000000F, 1'b0};
    vt[9]  = '{32'hFFFFFFFF, 3'd6, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vt[10] = '{32'h7FF00013, 3'd0, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    vt[11] = '{32'hFFFFF06F, 3'd4, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0};
    vt[12] = '{32'h02000013, 3'd5, 32'h00000000, 64'h0000000000000020, 1'b0};
    vt[13] = '{32'h00000013, 3'd0, 32'h00000000, 64'h0000000000000000, 1'b0};

    // Reset with an input presented: it must be discarded.
    drive(vt[0]);
    tick(); tick();
    idle_chk("rst");
    check("rst in_ready32", 64'(ir32), 64'd1);
    check("rst in_ready64", 64'(ir64), 64'd1);
    check("rst imm64", im64, 64'd0);
    check("rst err64", 64'(er64), 64'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    idle_chk("post rst");

    // Table: back-to-back stream, out_ready high, no bubbles allowed.
    drive(vt[0]);
    for (int i = 0; i < 14; i++) begin
      tick();
      exp_chk($sformatf("vec%0d", i), vt[i]);
      check($sformatf("vec%0d in_ready", i), 64'(ir64 & ir32), 64'd1);
      if (i < 13) drive(vt[i+1]);
      else in_valid = 1'b0;
    end
    tick();
    idle_chk("drain");

    // Backpressure: A held, B into skid, C refused, then A,B,C,D in order.
    drive(vt[1]);
    tick();
    exp_chk("bp A", vt[1]);
    out_ready = 1'b0;
    drive(vt[2]);
    tick();
    exp_chk("bp A held1", vt[1]);
    check("bp in_ready low", 64'(ir32 | ir64), 64'd0);
    drive(vt[3]);
    tick();
    exp_chk("bp A held2", vt[1]);
    check("bp C refused", 64'(ir32 | ir64), 64'd0);
    tick();
    exp_chk("bp A held3", vt[1]);
    out_ready = 1'b1;
    tick();
    exp_chk("bp B", vt[2]);
    check("bp in_ready back", 64'(ir32 & ir64), 64'd1);
    tick();
    exp_chk("bp C", vt[3]);
    drive(vt[4]);
    tick();
    exp_chk("bp D", vt[4]);
    in_valid = 1'b0;
    tick();
    idle_chk("bp end");

    // Reset while both registers are full.
    out_ready = 1'b0;
    drive(vt[6]);
    tick();
    drive(vt[7]);
    tick();
    check("ms skid full", 64'(ir32 | ir64), 64'd0);
    rst = 1'b1;
    drive(vt[8]);
    tick();
    idle_chk("ms rst");
    check("ms in_ready", 64'(ir32 & ir64), 64'd1);
    check("ms imm64", im64, 64'd0);
    check("ms err", 64'(er32 | er64), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(vt[11]);
    tick();
    exp_chk("ms alone", vt[11]);
    in_valid = 1'b0;
    tick();
    idle_chk("ms after");

    // Random handshake against a reference queue.
    begin
      int sent, recv, cyc;
      logic held;
      logic [63:0] h64;
      logic [31:0] h32;
      logic        herr;
      exp_t e;
      sent = 0; recv = 0; cyc = 0; held = 1'b0;
      h64 = '0; h32 = '0; herr = 1'b0;
      while (recv < 10000 && cyc < 80000) begin
        if (held) begin
          check("rnd stable64", {im64[63:1], er64}, {h64[63:1], herr});
          check("rnd stable32", 64'(im32), 64'(h32));
        end
        in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
        instr     = $urandom;
        ImmSrc    = 3'($urandom_range(7));
        out_ready = ($urandom_range(3) != 0);
        check("rnd ready agree", 64'(ir32 ^ ir64), 64'd0);
        if (in_valid && ir64) begin
          q.push_back(model(instr, ImmSrc));
          sent++;
        end
        if (ov64 && out_ready) begin
          if (q.size() == 0) begin
            check("rnd spurious out", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check("rnd imm64", im64, e.e64);
            check("rnd imm32", 64'(im32), 64'(e.e32));
            check("rnd err", {62'd0, er32, er64}, {62'd0, e.err, e.err});
          end
          recv++;
        end
        held = ov64 && !out_ready;
        h64 = im64; h32 = im32; herr = er64;
        tick();
        cyc++;
      end
      check("rnd all received", 64'(recv), 64'd10000);
      check("rnd queue empty", 64'(q.size()), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
